// File: rtl/icache_pkg.sv
// Shared types, default geometry and address helpers for the I-cache line-fill controller.
package icache_pkg;

    localparam int unsigned LINE_WORDS_DEF = 4;
    localparam int unsigned ADDR_WIDTH_DEF = 32;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned SET_BITS_DEF   = 6;

    localparam int unsigned WORD_OFF_W = $clog2(LINE_WORDS_DEF);
    localparam int unsigned SET_W      = SET_BITS_DEF;
    localparam int unsigned TAG_W      = ADDR_WIDTH_DEF - SET_BITS_DEF - WORD_OFF_W - 2;

    // Widest address the alignment helper handles; callers cast down to their own width.
    localparam int unsigned MAX_ADDR_W = 64;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StFill,
        StCommit
    } fill_state_t;

    // Clears the lsb_bits lowest address bits.
    function automatic logic [MAX_ADDR_W-1:0] align_addr(input logic [MAX_ADDR_W-1:0] addr,
                                                         input int unsigned lsb_bits);
        logic [MAX_ADDR_W-1:0] mask;
        mask = {MAX_ADDR_W{1'b1}} << lsb_bits;
        return addr & mask;
    endfunction

endpackage

// File: rtl/icache_fill_ctrl.sv
// I-cache line-fill controller: latch miss, burst request, write beats, one-cycle tag commit.
// Define ICACHE_FILL_CWF_EN for critical-word-first bursts (wrap within the line).
module icache_fill_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned SET_BITS   = SET_BITS_DEF,
    localparam int unsigned OFF_W     = $clog2(LINE_WORDS),
    localparam int unsigned TAG_BITS  = ADDR_WIDTH - SET_BITS - OFF_W - 2
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  instr_miss_f_i,
    input  logic [ADDR_WIDTH-1:0] pc_f_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  fill_we_o,
    output logic [SET_BITS-1:0]   fill_set_o,
    output logic [OFF_W-1:0]      fill_word_o,
    output logic [DATA_WIDTH-1:0] fill_data_o,
    output logic [TAG_BITS-1:0]   fill_tag_o,
    output logic                  instr_cache_rep_active_o,
    output logic                  busy_o
);

`ifdef ICACHE_FILL_CWF_EN
    localparam int unsigned ReqLsb = 2;
`else
    localparam int unsigned ReqLsb = OFF_W + 2;
`endif

    fill_state_t           state_q, state_d;
    logic [OFF_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
    logic [OFF_W-1:0]      start_word;

`ifdef ICACHE_FILL_CWF_EN
    assign start_word = miss_addr_q[OFF_W+1:2];
`else
    assign start_word = '0;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= StIdle;
            beat_cnt_q  <= '0;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    always_comb begin
        state_d                  = state_q;
        beat_cnt_d               = beat_cnt_q;
        miss_addr_d              = miss_addr_q;
        mem_req_o                = 1'b0;
        mem_addr_o               = '0;
        fill_we_o                = 1'b0;
        fill_word_o              = '0;
        fill_data_o              = '0;
        instr_cache_rep_active_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (instr_miss_f_i) begin
                    miss_addr_d = pc_f_i;
                    state_d     = StReq;
                end
            end
            StReq: begin
                mem_req_o  = 1'b1;
                mem_addr_o = ADDR_WIDTH'(align_addr(MAX_ADDR_W'(miss_addr_q), ReqLsb));
                if (mem_ready_i) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                if (mem_rvalid_i) begin
                    fill_we_o   = 1'b1;
                    // Power-of-two line: the add wraps within the line for free.
                    fill_word_o = start_word + beat_cnt_q;
                    fill_data_o = mem_rdata_i;
                    beat_cnt_d  = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == OFF_W'(LINE_WORDS - 1)) begin
                        state_d = StCommit;
                    end
                end
            end
            StCommit: begin
                instr_cache_rep_active_o = 1'b1;
                state_d                  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy_o     = (state_q != StIdle);
    assign fill_set_o = busy_o ? miss_addr_q[OFF_W+2 +: SET_BITS] : '0;
    assign fill_tag_o = busy_o ? miss_addr_q[ADDR_WIDTH-1 -: TAG_BITS] : '0;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed self-checking bench for icache_fill_ctrl; expectations follow ICACHE_FILL_CWF_EN.
module tb_icache_fill_ctrl;

    localparam int unsigned LW = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SB = 6;
    localparam int unsigned OW = 2;
    localparam int unsigned TW = 22;
`ifdef ICACHE_FILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          instr_miss_f_i;
    logic [AW-1:0] pc_f_i;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_ready_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          fill_we_o;
    logic [SB-1:0] fill_set_o;
    logic [OW-1:0] fill_word_o;
    logic [DW-1:0] fill_data_o;
    logic [TW-1:0] fill_tag_o;
    logic          instr_cache_rep_active_o;
    logic          busy_o;

    int n_cmp = 0;
    int n_err = 0;

    icache_fill_ctrl #(
        .LINE_WORDS(LW),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .SET_BITS  (SB)
    ) u_dut (
        .clk_i                   (clk_i),
        .reset_n_i               (reset_n_i),
        .instr_miss_f_i          (instr_miss_f_i),
        .pc_f_i                  (pc_f_i),
        .mem_req_o               (mem_req_o),
        .mem_addr_o              (mem_addr_o),
        .mem_ready_i             (mem_ready_i),
        .mem_rvalid_i            (mem_rvalid_i),
        .mem_rdata_i             (mem_rdata_i),
        .fill_we_o               (fill_we_o),
        .fill_set_o              (fill_set_o),
        .fill_word_o             (fill_word_o),
        .fill_data_o             (fill_data_o),
        .fill_tag_o              (fill_tag_o),
        .instr_cache_rep_active_o(instr_cache_rep_active_o),
        .busy_o                  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive point: just after the rising edge; sample point: falling edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    function automatic int exp_word(input int start, input int i);
        return CWF ? (start + i) % LW : i;
    endfunction

    task automatic beat(input string tag, input int start, input int idx, input logic [31:0] data);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = data;
        smp();
        check({tag, "_we"}, 64'(fill_we_o), 64'd1);
        check({tag, "_word"}, 64'(fill_word_o), 64'(exp_word(start, idx)));
        check({tag, "_data"}, 64'(fill_data_o), 64'(data));
        check({tag, "_req"}, 64'(mem_req_o), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 64'(mem_req_o), 64'd0);
        check({tag, "_addr"}, 64'(mem_addr_o), 64'd0);
        check({tag, "_we"}, 64'(fill_we_o), 64'd0);
        check({tag, "_set"}, 64'(fill_set_o), 64'd0);
        check({tag, "_word"}, 64'(fill_word_o), 64'd0);
        check({tag, "_data"}, 64'(fill_data_o), 64'd0);
        check({tag, "_tag"}, 64'(fill_tag_o), 64'd0);
        check({tag, "_rep"}, 64'(instr_cache_rep_active_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] gap_pat;
        int         b;

        reset_n_i      = 1'b0;
        instr_miss_f_i = 1'b0;
        pc_f_i         = '0;
        mem_ready_i    = 1'b0;
        mem_rvalid_i   = 1'b0;
        mem_rdata_i    = '0;
        smp();
        check_all_zero("reset");
        cyc();
        cyc();
        reset_n_i = 1'b1;

        // Basic fill: miss 0x1048 -> set 0x04, tag 0x4, word offset 2.
        cyc();
        instr_miss_f_i = 1'b1;
        pc_f_i         = 32'h0000_1048;
        smp();
        check("t1_idle_req", 64'(mem_req_o), 64'd0);
        check("t1_idle_busy", 64'(busy_o), 64'd0);
        cyc();
        instr_miss_f_i = 1'b0;
        mem_ready_i    = 1'b1;
        smp();
        check("t1_req", 64'(mem_req_o), 64'd1);
        check("t1_addr", 64'(mem_addr_o), CWF ? 64'h1048 : 64'h1040);
        check("t1_set", 64'(fill_set_o), 64'h04);
        check("t1_tag", 64'(fill_tag_o), 64'h4);
        check("t1_busy", 64'(busy_o), 64'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            mem_ready_i = 1'b0;
            beat($sformatf("t1_b%0d", i), 2, i, 32'hC0DE_0000 + 32'(i));
        end
        cyc();
        mem_rvalid_i = 1'b0;
        smp();
        check("t1_rep", 64'(instr_cache_rep_active_o), 64'd1);
        check("t1_rep_set", 64'(fill_set_o), 64'h04);
        check("t1_rep_tag", 64'(fill_tag_o), 64'h4);
        check("t1_rep_we", 64'(fill_we_o), 64'd0);
        cyc();
        smp();
        check("t1_after_rep", 64'(instr_cache_rep_active_o), 64'd0);
        check("t1_after_busy", 64'(busy_o), 64'd0);

        // Backpressure then gapped beats: miss 0x2000_0104 -> set 0x10, tag 0x80000, offset 1.
        cyc();
        instr_miss_f_i = 1'b1;
        pc_f_i         = 32'h2000_0104;
        smp();
        for (int i = 0; i < 4; i++) begin
            cyc();
            instr_miss_f_i = 1'b0;
            mem_ready_i    = (i == 3);
            smp();
            check($sformatf("t2_req%0d", i), 64'(mem_req_o), 64'd1);
            check($sformatf("t2_addr%0d", i), 64'(mem_addr_o),
                  CWF ? 64'h2000_0104 : 64'h2000_0100);
        end
        gap_pat = 7'b1011001;  // bit k = beat valid in gap cycle k: 1,0,0,1,1,0,1
        b       = 0;
        for (int k = 0; k < 7; k++) begin
            cyc();
            mem_ready_i  = 1'b0;
            mem_rvalid_i = gap_pat[k];
            mem_rdata_i  = 32'h5A5A_0000 + 32'(b);
            smp();
            check($sformatf("t3_we%0d", k), 64'(fill_we_o), 64'(gap_pat[k]));
            check($sformatf("t3_rep%0d", k), 64'(instr_cache_rep_active_o), 64'd0);
            check($sformatf("t3_req%0d", k), 64'(mem_req_o), 64'd0);
            if (gap_pat[k]) begin
                check($sformatf("t3_word%0d", k), 64'(fill_word_o), 64'(exp_word(1, b)));
                check($sformatf("t3_data%0d", k), 64'(fill_data_o), 64'(32'h5A5A_0000 + 32'(b)));
                b++;
            end
        end
        cyc();
        mem_rvalid_i = 1'b0;
        smp();
        check("t3_rep", 64'(instr_cache_rep_active_o), 64'd1);
        check("t3_set", 64'(fill_set_o), 64'h10);
        check("t3_tag", 64'(fill_tag_o), 64'h8_0000);
        cyc();
        smp();
        check("t3_idle", 64'(busy_o), 64'd0);

        // Reset after two beats; leftover beats must be ignored afterwards.
        cyc();
        instr_miss_f_i = 1'b1;
        pc_f_i         = 32'h0000_1048;
        cyc();
        instr_miss_f_i = 1'b0;
        mem_ready_i    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            mem_ready_i = 1'b0;
            beat($sformatf("t5_b%0d", i), 2, i, 32'h7700_0000 + 32'(i));
        end
        cyc();
        reset_n_i   = 1'b0;
        mem_rdata_i = 32'h7700_0002;
        smp();
        check_all_zero("t5_rst");
        for (int i = 0; i < 2; i++) begin
            cyc();
            reset_n_i = 1'b1;
            smp();
            check($sformatf("t5_left_we%0d", i), 64'(fill_we_o), 64'd0);
            check($sformatf("t5_left_busy%0d", i), 64'(busy_o), 64'd0);
        end

        // Miss held high through the fill: 0x30FC -> set 0x0F, tag 0xC, offset 3.
        cyc();
        mem_rvalid_i   = 1'b0;
        instr_miss_f_i = 1'b1;
        pc_f_i         = 32'h0000_30FC;
        cyc();
        mem_ready_i = 1'b1;
        smp();
        check("t6_req", 64'(mem_req_o), 64'd1);
        check("t6_addr", 64'(mem_addr_o), CWF ? 64'h30FC : 64'h30F0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            mem_ready_i = 1'b0;
            beat($sformatf("t6_b%0d", i), 3, i, 32'h1234_0000 + 32'(i));
        end
        cyc();
        mem_rvalid_i = 1'b0;
        smp();
        check("t6_rep", 64'(instr_cache_rep_active_o), 64'd1);
        check("t6_rep_req", 64'(mem_req_o), 64'd0);
        check("t6_rep_set", 64'(fill_set_o), 64'h0F);
        check("t6_rep_tag", 64'(fill_tag_o), 64'hC);
        cyc();
        smp();
        check("t6_idle_busy", 64'(busy_o), 64'd0);
        check("t6_idle_req", 64'(mem_req_o), 64'd0);
        cyc();
        instr_miss_f_i = 1'b0;
        mem_ready_i    = 1'b1;
        smp();
        check("t6_req2", 64'(mem_req_o), 64'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            mem_ready_i = 1'b0;
            beat($sformatf("t6_2b%0d", i), 3, i, 32'h4321_0000 + 32'(i));
        end
        cyc();
        mem_rvalid_i = 1'b0;
        smp();
        check("t6_rep2", 64'(instr_cache_rep_active_o), 64'd1);
        cyc();
        smp();
        check("t6_end_busy", 64'(busy_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
